// File: rtl/store_write_buffer_if.sv
// Store write buffer bus bundle.
//   Groups the core store port, the load-forwarding port, the memory drain
//   port and the occupancy status of the store write buffer.
//   master : the core/memory side (drives store, load address, mem_wready)
//   slave  : the buffer itself (drives stall, forwarding, drain, status)
interface store_write_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    // core store port
    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic          stall;
    // load forwarding port
    logic [AW-1:0] ld_adr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    // memory drain port
    logic          mem_wvalid;
    logic          mem_wready;
    logic [AW-1:0] mem_wadr;
    logic [DW-1:0] mem_wdata;
    // status
    logic          empty;
    logic [CW-1:0] count;

    modport master (
        output memwrite, dataadr, writedata, ld_adr, mem_wready,
        input  stall, ld_hit, ld_data, mem_wvalid, mem_wadr, mem_wdata, empty, count
    );

    modport slave (
        input  memwrite, dataadr, writedata, ld_adr, mem_wready,
        output stall, ld_hit, ld_data, mem_wvalid, mem_wadr, mem_wdata, empty, count
    );
endinterface

// File: rtl/store_write_buffer.sv
// Store write buffer.
//   FIFO between the core store port and data memory. A store is captured in
//   one cycle and drained in order over a valid/ready port. The core is
//   stalled while the buffer is full. Loads that hit a pending word address
//   are forwarded the youngest matching buffered data.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low; clears all pending stores
//   bus    store_write_buffer_if.slave (store, forwarding, drain, status)
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    store_write_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Entry storage is not reset: validity comes from rd_ptr/count alone,
    // and every output derived from it is gated by that validity.
    logic [AW-1:0] adr_q  [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic full, empty, push, pop;

    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] entry_match;

    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [PW-1:0] fwd_idx;

    // Full is decided from count only, so a same-cycle pop never lets a
    // store in while the buffer is full.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.memwrite & ~full;
    assign pop   = ~empty & bus.mem_wready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            adr_q[wr_ptr_q]  <= bus.dataadr;
            data_q[wr_ptr_q] <= bus.writedata;
        end
    end

    // Per-entry validity and word-address match. An entry is valid when its
    // age (distance from the head, modulo DEPTH) is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [PW-1:0] age;
        assign age              = PW'(gi) - rd_ptr_q;
        assign entry_valid[gi]  = ({1'b0, age} < count_q);
        assign entry_match[gi]  = entry_valid[gi] &&
                                  (adr_q[gi][AW-1:2] == bus.ld_adr[AW-1:2]);
    end

    // Walk entries oldest to youngest; the last match seen is the youngest.
    // The incoming store is not yet an entry, so it is never forwarded.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr_q + PW'(k);
            if (entry_match[fwd_idx]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    assign bus.stall      = bus.memwrite & full;
    assign bus.ld_hit     = fwd_hit;
    assign bus.ld_data    = fwd_data;
    assign bus.mem_wvalid = ~empty;
    assign bus.mem_wadr   = empty ? '0 : adr_q[rd_ptr_q];
    assign bus.mem_wdata  = empty ? '0 : data_q[rd_ptr_q];
    assign bus.empty      = empty;
    assign bus.count      = count_q;
endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_write_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
    } ent_t;
    ent_t q[$];

    typedef struct {
        logic          memwrite;
        logic [AW-1:0] dataadr;
        logic [DW-1:0] writedata;
        logic [AW-1:0] ld_adr;
        logic          exp_hit;
        logic [DW-1:0] exp_data;
    } fwd_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: pending stores as a queue, head at index 0.
    task automatic check_model(input string tag);
        logic          hit;
        logic [DW-1:0] fdata;
        int            n;
        n     = q.size();
        hit   = 1'b0;
        fdata = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (q[i].adr[AW-1:2] == bus.ld_adr[AW-1:2]) begin
                hit   = 1'b1;
                fdata = q[i].data;
                break;
            end
        end
        check({tag, ".count"},  64'(bus.count), 64'(n));
        check({tag, ".empty"},  64'(bus.empty), 64'(n == 0));
        check({tag, ".wvalid"}, 64'(bus.mem_wvalid), 64'(n != 0));
        check({tag, ".stall"},  64'(bus.stall), 64'(bus.memwrite && n == DEPTH));
        check({tag, ".wadr"},   64'(bus.mem_wadr), 64'(n != 0 ? q[0].adr : '0));
        check({tag, ".wdata"},  64'(bus.mem_wdata), 64'(n != 0 ? q[0].data : '0));
        check({tag, ".ld_hit"}, 64'(bus.ld_hit), 64'(hit));
        check({tag, ".ld_data"},64'(bus.ld_data), 64'(fdata));
    endtask

    task automatic model_edge();
        bit pop, push;
        if (!reset) begin
            q.delete();
        end else begin
            pop  = (q.size() != 0) && bus.mem_wready;
            push = bus.memwrite && (q.size() < DEPTH);
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{adr: bus.dataadr, data: bus.writedata});
        end
    endtask

    // Settle, optionally compare with the model, then clock one edge.
    task automatic cycle(input bit chk, input string tag);
        #1;
        if (chk) check_model(tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_store(input logic mw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.memwrite  = mw;
        bus.dataadr   = a;
        bus.writedata = d;
    endtask

    fwd_vec_t fwd_tbl[8];
    logic [AW-1:0] exp_order[4];

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b0;
        set_store(1'b1, 32'd100, 32'hdead);
        bus.ld_adr     = '0;
        bus.mem_wready = 1'b0;

        // 1: reset for two cycles with memwrite held high
        cycle(1'b0, "rst0");
        cycle(1'b0, "rst1");
        set_store(1'b0, '0, '0);
        #1;
        check("reset.count", 64'(bus.count), 64'd0);
        check("reset.empty", 64'(bus.empty), 64'd1);
        check("reset.wvalid", 64'(bus.mem_wvalid), 64'd0);
        check("reset.ld_hit", 64'(bus.ld_hit), 64'd0);
        reset = 1'b1;

        // 2: single store then drain
        set_store(1'b1, 32'd84, 32'd7);
        cycle(1'b1, "single.push");
        set_store(1'b0, '0, '0);
        #1;
        check("single.wvalid", 64'(bus.mem_wvalid), 64'd1);
        check("single.wadr", 64'(bus.mem_wadr), 64'd84);
        check("single.wdata", 64'(bus.mem_wdata), 64'd7);
        check("single.count", 64'(bus.count), 64'd1);
        bus.mem_wready = 1'b1;
        cycle(1'b1, "single.pop");
        bus.mem_wready = 1'b0;
        #1;
        check("single.empty", 64'(bus.empty), 64'd1);

        // 3: fill, stall, drain one, stalled store enters, drain order
        for (int i = 0; i < 4; i++) begin
            set_store(1'b1, 32'(4 * i), 32'(i + 1));
            cycle(1'b1, "fill");
        end
        set_store(1'b1, 32'd16, 32'd5);
        #1;
        check("full.count", 64'(bus.count), 64'd4);
        check("full.stall", 64'(bus.stall), 64'd1);
        cycle(1'b1, "full.hold");
        bus.mem_wready = 1'b1;
        cycle(1'b1, "full.pop");
        bus.mem_wready = 1'b0;
        #1;
        check("full.after_pop.count", 64'(bus.count), 64'd3);
        check("full.after_pop.stall", 64'(bus.stall), 64'd0);
        cycle(1'b1, "full.accept");
        set_store(1'b0, '0, '0);
        exp_order = '{32'd4, 32'd8, 32'd12, 32'd16};
        bus.mem_wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("order[%0d]", i), 64'(bus.mem_wadr), 64'(exp_order[i]));
            cycle(1'b1, "drain");
        end
        bus.mem_wready = 1'b0;
        #1;
        check("drain.empty", 64'(bus.empty), 64'd1);

        // 4: simultaneous push/pop at count 2, then wrap
        for (int i = 0; i < 2; i++) begin
            set_store(1'b1, 32'(32 + 4 * i), 32'(20 + i));
            cycle(1'b1, "pp.fill");
        end
        bus.mem_wready = 1'b1;
        set_store(1'b1, 32'd48, 32'd30);
        cycle(1'b1, "pp.both");
        check("pp.count", 64'(bus.count), 64'd2);
        for (int i = 0; i < 10; i++) begin
            set_store(1'b1, 32'(64 + 4 * i), 32'(100 + i));
            cycle(1'b1, "pp.wrap");
        end
        set_store(1'b0, '0, '0);
        for (int i = 0; i < 3; i++) cycle(1'b1, "pp.drain");
        bus.mem_wready = 1'b0;

        // 5: forwarding table
        set_store(1'b1, 32'd84, 32'd7);  cycle(1'b1, "fwd.s0");
        set_store(1'b1, 32'd84, 32'd9);  cycle(1'b1, "fwd.s1");
        set_store(1'b1, 32'd88, 32'd5);  cycle(1'b1, "fwd.s2");
        fwd_tbl[0] = '{1'b0, 32'd0,  32'd0,  32'd86, 1'b1, 32'd9};
        fwd_tbl[1] = '{1'b0, 32'd0,  32'd0,  32'd92, 1'b0, 32'd0};
        fwd_tbl[2] = '{1'b0, 32'd0,  32'd0,  32'd88, 1'b1, 32'd5};
        fwd_tbl[3] = '{1'b0, 32'd0,  32'd0,  32'd84, 1'b1, 32'd9};
        fwd_tbl[4] = '{1'b0, 32'd0,  32'd0,  32'd91, 1'b1, 32'd5};
        fwd_tbl[5] = '{1'b0, 32'd0,  32'd0,  32'd80, 1'b0, 32'd0};
        fwd_tbl[6] = '{1'b1, 32'd92, 32'd33, 32'd92, 1'b0, 32'd0};
        fwd_tbl[7] = '{1'b1, 32'd84, 32'd44, 32'd85, 1'b1, 32'd9};
        for (int i = 0; i < 8; i++) begin
            set_store(fwd_tbl[i].memwrite, fwd_tbl[i].dataadr, fwd_tbl[i].writedata);
            bus.ld_adr = fwd_tbl[i].ld_adr;
            #1;
            check($sformatf("fwd[%0d].hit", i), 64'(bus.ld_hit), 64'(fwd_tbl[i].exp_hit));
            check($sformatf("fwd[%0d].data", i), 64'(bus.ld_data), 64'(fwd_tbl[i].exp_data));
        end
        set_store(1'b0, '0, '0);
        // head (84,7) pops this cycle yet (84,9) is still youngest; 88 forwards too
        bus.mem_wready = 1'b1;
        bus.ld_adr = 32'd88;
        #1;
        check("fwd.popping.hit", 64'(bus.ld_hit), 64'd1);
        check("fwd.popping.data", 64'(bus.ld_data), 64'd5);
        bus.mem_wready = 1'b0;
        bus.ld_adr = '0;

        // 6: mid-operation reset with three pending stores
        #1;
        check("midrst.count_before", 64'(bus.count), 64'd3);
        reset = 1'b0;
        cycle(1'b0, "midrst");
        reset = 1'b1;
        #1;
        check("midrst.empty", 64'(bus.empty), 64'd1);
        check("midrst.wvalid", 64'(bus.mem_wvalid), 64'd0);
        bus.mem_wready = 1'b1;
        bus.ld_adr = 32'd84;
        for (int i = 0; i < 3; i++) cycle(1'b1, "midrst.idle");
        bus.mem_wready = 1'b0;

        // Randomized traffic against the queue model; stalled stores held.
        begin
            bit stalled;
            stalled = 1'b0;
            for (int i = 0; i < 500; i++) begin
                if (!stalled) begin
                    set_store(1'($urandom_range(0, 2) != 0),
                              32'h100 + 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)),
                              $urandom);
                end
                bus.mem_wready = 1'($urandom_range(0, 2) == 0);
                bus.ld_adr     = 32'h100 + 32'($urandom_range(0, 8) * 4 + $urandom_range(0, 3));
                #1;
                stalled = bus.memwrite && (q.size() == DEPTH);
                cycle(1'b1, "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
